// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, bit-timing and parity helpers.
// Imported by the transmit block and intended for reuse by the receive block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // odd=0 gives even parity (bit makes the total count of ones even)
    function automatic logic tx_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period cycle counter: bit_tick marks the last cycle of the current bit period.
// Held at zero while disabled; cleared synchronously on accept and at each bit boundary.
module uart_baud_tick #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] last_cnt,
    output logic             bit_tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = en && (cnt == last_cnt);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on tx_start/tx_ready and sends it LSB-first
// framed by a start bit, optional parity bit and one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = $clog2(2 * CPB);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CPB - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t        state, state_next;
    logic             tx_next;
    logic             done_next;
    logic [2:0]       bit_idx, idx_next;
    logic             cnt_clear;
    logic             shift_en;
    logic             bit_tick;
    logic             accept;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic [CNT_W-1:0] last_cnt;

    assign tx_ready = (state == IDLE);
    assign accept   = tx_ready && tx_start;
    // The stop period may span two bit times, so the counter terminal count widens there
    assign last_cnt = (state == STOP) ? STOP_LAST : BIT_LAST;

    uart_baud_tick #(
        .CNT_W (CNT_W)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .en       (state != IDLE),
        .last_cnt (last_cnt),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            tx_done <= done_next;
            bit_idx <= idx_next;
        end
    end

    // Payload and parity are latched at accept, so later tx_data changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg  <= tx_data;
            parity_reg <= tx_parity(tx_data, PARITY_ODD != 0);
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    always_comb begin
        state_next = state;
        tx_next    = tx;
        done_next  = 1'b0;
        idx_next   = bit_idx;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    state_next = START;
                    tx_next    = 1'b0;
                    idx_next   = 3'd0;
                    cnt_clear  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                    cnt_clear  = 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_clear = 1'b1;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // shift_reg[1] is the next bit out once the register shifts
                        idx_next = bit_idx + 3'd1;
                        tx_next  = shift_reg[1];
                        shift_en = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    done_next  = 1'b1;
                    cnt_clear  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// decodes the serial output cycle by cycle and compares against the queue.
module tb_uart_tx;

    localparam int CPB = 104;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par;
        int         stop;
        int         acc;
        logic       b2b;
    } item_t;

    logic       clk;
    logic       rst;
    logic [7:0] data_v;
    logic       start_v;
    logic [1:0] sel;
    logic       mon_en;
    logic       mon_busy;

    logic tx0, tx1, tx2, rdy0, rdy1, rdy2, done0, done1, done2;
    logic line_tx, line_ready, line_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt0 = 0;

    item_t exp_q[$];

    assign line_tx    = (sel == 2'd0) ? tx0   : (sel == 2'd1) ? tx1   : tx2;
    assign line_ready = (sel == 2'd0) ? rdy0  : (sel == 2'd1) ? rdy1  : rdy2;
    assign line_done  = (sel == 2'd0) ? done0 : (sel == 2'd1) ? done1 : done2;

    uart_tx u_dut0 (
        .clk(clk), .rst(rst), .tx_data(data_v), .tx_start(start_v && sel == 2'd0),
        .tx_ready(rdy0), .tx(tx0), .tx_done(done0)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .tx_data(data_v), .tx_start(start_v && sel == 2'd1),
        .tx_ready(rdy1), .tx(tx1), .tx_done(done1)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(data_v), .tx_start(start_v && sel == 2'd2),
        .tx_ready(rdy2), .tx(tx2), .tx_done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_level(input item_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (e.par_en && b == 9) return e.par;
        return 1'b1;
    endfunction

    // Line monitor: sample 0 is the first negedge after the accept edge
    initial begin : monitor
        item_t e;
        int    len, bad, dbad, last_done;
        logic  prev, chk_low;
        prev      = 1'b1;
        chk_low   = 1'b0;
        last_done = -10;
        mon_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_low) begin
                chk("done_width", int'(line_done), 0);
                chk_low = 1'b0;
            end
            if (mon_en && !rst && prev && !line_tx) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_cycle", cyc, e.acc);
                    if (e.b2b) chk("b2b_gap", cyc - last_done, 1);
                    len  = (9 + int'(e.par_en) + e.stop) * CPB;
                    bad  = 0;
                    dbad = 0;
                    for (int s = 0; s < len; s++) begin
                        if (s > 0) @(negedge clk);
                        if (line_tx !== exp_level(e, s / CPB)) bad++;
                        if (line_done !== 1'b0) dbad++;
                    end
                    @(negedge clk);
                    chk("done_pulse", int'(line_done), 1);
                    chk("ready_at_done", int'(line_ready), 1);
                    chk("idle_at_done", int'(line_tx), 1);
                    chk("frame_bits", bad, 0);
                    chk("done_early", dbad, 0);
                    last_done = cyc;
                    chk_low   = 1'b1;
                end
                mon_busy = 1'b0;
            end
            prev = line_tx;
        end
    end

    task automatic send(input logic [7:0] d, input logic pe, input logic par,
                        input int stop, input logic push, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        while (!line_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", int'(line_ready), 1);
        data_v  = d;
        start_v = 1'b1;
        acc     = cyc + 1;
        if (push) exp_q.push_back('{data:d, par_en:pe, par:par, stop:stop, acc:acc, b2b:1'b0});
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", int'(t < 6000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        int acc, a1, zeros, dc0;
        rst     = 1'b1;
        start_v = 1'b0;
        data_v  = 8'h00;
        sel     = 2'd0;
        mon_en  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx0), 1);
        chk("rst_ready", int'(rdy0), 1);
        chk("rst_done", int'(done0), 0);
        rst = 1'b0;
        zeros = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || done0 !== 1'b0) zeros++;
        end
        chk("idle_high", zeros, 0);
        mon_en = 1'b1;

        // 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
        send(8'hA5, 1'b0, 1'b0, 1, 1'b1, acc);
        wait_idle();

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        sel = 2'd1;
        send(8'h07, 1'b1, 1'b1, 2, 1'b1, acc);
        wait_idle();
        sel = 2'd2;
        send(8'h07, 1'b1, 1'b0, 2, 1'b1, acc);
        wait_idle();

        // Back-to-back with tx_start held and tx_data disturbed mid-frame
        sel = 2'd0;
        @(negedge clk);
        data_v  = 8'h3C;
        start_v = 1'b1;
        a1      = cyc + 1;
        exp_q.push_back('{data:8'h3C, par_en:1'b0, par:1'b0, stop:1, acc:a1, b2b:1'b0});
        exp_q.push_back('{data:8'hC3, par_en:1'b0, par:1'b0, stop:1, acc:a1 + 1041, b2b:1'b1});
        while (cyc < a1 + 300) @(negedge clk);
        data_v = 8'hFF;
        while (cyc < a1 + 900) @(negedge clk);
        data_v = 8'hC3;
        while (cyc < a1 + 1041) @(negedge clk);
        start_v = 1'b0;
        data_v  = 8'hFF;
        wait_idle();

        // Reset mid-frame aborts 0x00; 0x81 accepted on first edge after release
        mon_en = 1'b0;
        dc0    = done_cnt0;
        send(8'h00, 1'b0, 1'b0, 1, 1'b0, acc);
        while (cyc < acc + 300) @(negedge clk);
        chk("abort_tx_low", int'(tx0), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_async", int'(tx0), 1);
        chk("abort_ready", int'(rdy0), 1);
        chk("abort_done", int'(done0), 0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        mon_en  = 1'b1;
        data_v  = 8'h81;
        start_v = 1'b1;
        exp_q.push_back('{data:8'h81, par_en:1'b0, par:1'b0, stop:1, acc:cyc + 1, b2b:1'b0});
        @(negedge clk);
        start_v = 1'b0;
        wait_idle();
        chk("abort_done_count", done_cnt0 - dc0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmit stage of the UART. It is the upstream peer of the receive block and drives the line that the receiver samples.
- Accepts one byte per valid/ready handshake and serialises it LSB-first as start, 8 data, optional parity and stop bits.
- Bit timing is derived from the on-board clock by a cycle counter. No derived clocks are generated.

Parameters:
- CLK_FREQ, 1000000, on-board clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits per second.
- PARITY_EN, 0, 1 inserts a parity bit after d7.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  on-board clock; all logic runs on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on the accept edge.
- tx_start  input  1  request to send (valid).
- tx_ready  output  1  high when idle; a byte can be accepted this cycle.
- tx  output  1  serial line output; idle level is 1.
- tx_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - While rst=1: state=IDLE, tx=1, tx_done=0, tx_ready=1, all counters at 0.
- Bit timing:
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); 104 at the defaults.
  - Elaboration error if CLKS_PER_BIT<2 or STOP_BITS not in {1,2}.
- Output timing:
  - tx is a registered output; it changes only on clk edges (or asynchronously on rst).
  - tx_ready = (state==IDLE); it is combinational from state.
- Handshake:
  - Accept occurs on an edge where tx_start=1 and tx_ready=1.
  - On that edge: latch tx_data into shift_reg, compute parity, state<=START, tx<=0, bit-cycle counter<=0.
  - tx_start while tx_ready=0 is ignored. There is no queueing and no error flag.
- States:
  - IDLE: tx=1. Go to START on accept.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx<=shift_reg[0].
  - DATA: hold each bit for CLKS_PER_BIT cycles, then shift right. After bit index 7 completes, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: hold tx = (^byte) XOR PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- tx_done:
  - Asserted on the edge where STOP moves to IDLE; high for exactly one cycle, in which tx_ready=1.
  - A tx_start in that cycle is accepted (back-to-back operation).
- Frame timing:
  - Frame length measured from the accept edge = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles. This is 1040 at the defaults.
  - Back-to-back frames have one extra idle-high cycle between them, so the effective stop time is STOP_BITS*CLKS_PER_BIT+1 cycles.
- Counters:
  - Bit-cycle counter is ceil(log2(2*CLKS_PER_BIT)) bits wide, which covers 2 stop bits.
  - Bit index counter is 3 bits. It does not wrap beyond 7; the DATA exit check is index==7 at the last cycle.
- Reset mid-frame: the frame is aborted. tx=1 immediately, no tx_done, and the next accept is possible on the first edge after rst deasserts.
- tx_data changing after accept has no effect on the frame in flight.

Decomposition:
- Package uart_pkg:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP} as 3-bit logic.
  - function clks_per_bit(clk_freq, baud_rate).
  - parity computation function.
  - This package is shared with the receive block for future cleanup.
- One sub-module: uart_baud_tick.
  - Cycle counter with sync clear (asserted on accept and at each bit boundary).
  - Outputs bit_tick, high on the last cycle of a bit period.
  - The FSM in uart_tx advances only on bit_tick.

Test Plan (all scenarios at default parameters unless noted, so CLKS_PER_BIT=104):
- Reset: assert rst for 3 cycles, then release -> tx=1, tx_ready=1, tx_done=0; the line stays high for 500 idle cycles.
- Single byte: send tx_data=0xA5 -> tx carries the sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 104 cycles. tx_done pulses one cycle, 1040 cycles after accept.
- Parity and two stop bits: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07 -> parity bit 1, then 208 cycles of tx=1; tx_done at 1248 cycles. With PARITY_ODD=1 the parity bit is 0.
- Back-to-back with busy ignore:
  - Hold tx_start=1, send 0x3C then 0xC3 -> second start bit begins one cycle after tx_done; both bytes decode correctly in the bench model.
  - Change tx_data to 0xFF mid-frame -> no effect.
- Reset mid-frame: send 0x00, then assert rst at cycle 300 -> tx=1 within the same cycle (asynchronous) and no tx_done. Send 0x81 after release -> a clean frame is produced.
